// File: rtl/sram_r1_w1_arbiter.sv
// Two-client round-robin arbiter in front of a 1R/1W synchronous SRAM.
// Read and write ports are arbitrated independently; same-address read/write collisions are resolved write-first.
module sram_r1_w1_arbiter #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 64,
    parameter int LG_DEPTH = 6
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                io_rreq_valid_0,
    input  logic [LG_DEPTH-1:0] io_rreq_addr_0,
    output logic                io_rreq_ready_0,
    output logic                io_rresp_valid_0,
    output logic [WIDTH-1:0]    io_rresp_data_0,
    input  logic                io_wreq_valid_0,
    input  logic [LG_DEPTH-1:0] io_wreq_addr_0,
    input  logic [WIDTH-1:0]    io_wreq_data_0,
    output logic                io_wreq_ready_0,

    input  logic                io_rreq_valid_1,
    input  logic [LG_DEPTH-1:0] io_rreq_addr_1,
    output logic                io_rreq_ready_1,
    output logic                io_rresp_valid_1,
    output logic [WIDTH-1:0]    io_rresp_data_1,
    input  logic                io_wreq_valid_1,
    input  logic [LG_DEPTH-1:0] io_wreq_addr_1,
    input  logic [WIDTH-1:0]    io_wreq_data_1,
    output logic                io_wreq_ready_1,

    output logic [LG_DEPTH-1:0] io_sram_addrR,
    input  logic [WIDTH-1:0]    io_sram_doutR,
    output logic [LG_DEPTH-1:0] io_sram_addrW,
    output logic [WIDTH-1:0]    io_sram_dinW,
    output logic                io_sram_weW
);

    if (DEPTH > (1 << LG_DEPTH)) begin : g_depthCheck
        $error("DEPTH does not fit in LG_DEPTH address bits");
    end

    logic                w_rdGnt0;
    logic                w_rdGnt1;
    logic                w_wrGnt0;
    logic                w_wrGnt1;
    logic                w_rdAny;
    logic                w_wrAny;
    logic                w_bypass;
    logic [WIDTH-1:0]    w_respData;

    logic                r_rrLastRd;
    logic                r_rrLastWr;
    logic                r_rdPend;
    logic                r_rdWho;
    logic                r_bypEn;
    logic [WIDTH-1:0]    r_bypData;

    // Grants depend only on current valids and the registered priority bit; reset blocks every grant.
    always_comb begin
        w_rdGnt0 = !reset && io_rreq_valid_0 && (!io_rreq_valid_1 || r_rrLastRd);
        w_rdGnt1 = !reset && io_rreq_valid_1 && (!io_rreq_valid_0 || !r_rrLastRd);
        w_wrGnt0 = !reset && io_wreq_valid_0 && (!io_wreq_valid_1 || r_rrLastWr);
        w_wrGnt1 = !reset && io_wreq_valid_1 && (!io_wreq_valid_0 || !r_rrLastWr);
        w_rdAny  = w_rdGnt0 || w_rdGnt1;
        w_wrAny  = w_wrGnt0 || w_wrGnt1;
    end

    assign io_rreq_ready_0 = w_rdGnt0;
    assign io_rreq_ready_1 = w_rdGnt1;
    assign io_wreq_ready_0 = w_wrGnt0;
    assign io_wreq_ready_1 = w_wrGnt1;

    assign io_sram_addrR = w_rdGnt1 ? io_rreq_addr_1 : io_rreq_addr_0;
    assign io_sram_addrW = w_wrGnt1 ? io_wreq_addr_1 : io_wreq_addr_0;
    assign io_sram_dinW  = w_wrGnt1 ? io_wreq_data_1 : io_wreq_data_0;
    assign io_sram_weW   = w_wrAny;

    // The RAM would return stale data on a same-cycle collision, so capture the write data instead.
    assign w_bypass = w_rdAny && w_wrAny && (io_sram_addrR == io_sram_addrW);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rrLastRd <= 1'b1;
            r_rrLastWr <= 1'b1;
            r_rdPend   <= 1'b0;
            r_rdWho    <= 1'b0;
            r_bypEn    <= 1'b0;
            r_bypData  <= '0;
        end else begin
            if (w_rdAny) begin
                r_rrLastRd <= w_rdGnt1;
            end
            if (w_wrAny) begin
                r_rrLastWr <= w_wrGnt1;
            end
            r_rdPend <= w_rdAny;
            r_rdWho  <= w_rdGnt1;
            r_bypEn  <= w_bypass;
            if (w_bypass) begin
                r_bypData <= io_sram_dinW;
            end
        end
    end

    // A pending response is suppressed while reset is high, so an in-flight read is silently dropped.
    assign w_respData       = r_bypEn ? r_bypData : io_sram_doutR;
    assign io_rresp_valid_0 = !reset && r_rdPend && !r_rdWho;
    assign io_rresp_valid_1 = !reset && r_rdPend && r_rdWho;
    assign io_rresp_data_0  = w_respData;
    assign io_rresp_data_1  = w_respData;

endmodule

// File: tb/tb_sram_r1_w1_arbiter.sv
// Directed self-checking bench for sram_r1_w1_arbiter with a behavioural read-old-on-collision SRAM.
module tb_sram_r1_w1_arbiter;

    logic       clk;
    logic       reset;
    logic       rreqValid0, rreqValid1, wreqValid0, wreqValid1;
    logic [5:0] rreqAddr0, rreqAddr1, wreqAddr0, wreqAddr1;
    logic [7:0] wreqData0, wreqData1;
    logic       rreqReady0, rreqReady1, wreqReady0, wreqReady1;
    logic       rrespValid0, rrespValid1;
    logic [7:0] rrespData0, rrespData1;
    logic [5:0] sramAddrR, sramAddrW;
    logic [7:0] sramDoutR, sramDinW;
    logic       sramWeW;
    logic [7:0] mem [0:63];

    int checks = 0;
    int errors = 0;

    sram_r1_w1_arbiter #(.WIDTH(8), .DEPTH(64), .LG_DEPTH(6)) dut (
        .clk              (clk),
        .reset            (reset),
        .io_rreq_valid_0  (rreqValid0),
        .io_rreq_addr_0   (rreqAddr0),
        .io_rreq_ready_0  (rreqReady0),
        .io_rresp_valid_0 (rrespValid0),
        .io_rresp_data_0  (rrespData0),
        .io_wreq_valid_0  (wreqValid0),
        .io_wreq_addr_0   (wreqAddr0),
        .io_wreq_data_0   (wreqData0),
        .io_wreq_ready_0  (wreqReady0),
        .io_rreq_valid_1  (rreqValid1),
        .io_rreq_addr_1   (rreqAddr1),
        .io_rreq_ready_1  (rreqReady1),
        .io_rresp_valid_1 (rrespValid1),
        .io_rresp_data_1  (rrespData1),
        .io_wreq_valid_1  (wreqValid1),
        .io_wreq_addr_1   (wreqAddr1),
        .io_wreq_data_1   (wreqData1),
        .io_wreq_ready_1  (wreqReady1),
        .io_sram_addrR    (sramAddrR),
        .io_sram_doutR    (sramDoutR),
        .io_sram_addrW    (sramAddrW),
        .io_sram_dinW     (sramDinW),
        .io_sram_weW      (sramWeW)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model returns the old contents on a same-address read/write, exposing any missing bypass.
    always @(posedge clk) begin
        if (sramWeW) begin
            mem[sramAddrW] <= sramDinW;
        end
        sramDoutR <= mem[sramAddrR];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResp(input string tag, input logic v0, input logic v1, input logic [7:0] data);
        checkOutput({tag, ".rvalid0"}, 32'(rrespValid0), 32'(v0));
        checkOutput({tag, ".rvalid1"}, 32'(rrespValid1), 32'(v1));
        if (v0) checkOutput({tag, ".rdata0"}, 32'(rrespData0), 32'(data));
        if (v1) checkOutput({tag, ".rdata1"}, 32'(rrespData1), 32'(data));
    endtask

    task automatic checkReady(input string tag, input logic r0, input logic r1, input logic w0, input logic w1);
        checkOutput({tag, ".rready0"}, 32'(rreqReady0), 32'(r0));
        checkOutput({tag, ".rready1"}, 32'(rreqReady1), 32'(r1));
        checkOutput({tag, ".wready0"}, 32'(wreqReady0), 32'(w0));
        checkOutput({tag, ".wready1"}, 32'(wreqReady1), 32'(w1));
        checkOutput({tag, ".weW"}, 32'(sramWeW), 32'(w0 | w1));
    endtask

    // Drive one cycle's inputs just after the clock edge and let the combinational outputs settle.
    task automatic applyStimulus(input logic rst,
                                 input logic rv0, input logic [5:0] ra0,
                                 input logic rv1, input logic [5:0] ra1,
                                 input logic wv0, input logic [5:0] wa0, input logic [7:0] wd0,
                                 input logic wv1, input logic [5:0] wa1, input logic [7:0] wd1);
        reset      = rst;
        rreqValid0 = rv0; rreqAddr0 = ra0;
        rreqValid1 = rv1; rreqAddr1 = ra1;
        wreqValid0 = wv0; wreqAddr0 = wa0; wreqData0 = wd0;
        wreqValid1 = wv1; wreqAddr1 = wa1; wreqData1 = wd1;
        #2;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 6'd0, 0, 6'd0, 0, 6'd0, 8'h00, 0, 6'd0, 8'h00);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        sramDoutR = 8'h00;

        $display("[TB] reset with all valids high");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 6'd1, 1, 6'd2, 1, 6'd5, 8'h00, 1, 6'd9, 8'hEE);
            checkReady($sformatf("rst%0d", i), 0, 0, 0, 0);
            checkResp($sformatf("rst%0d", i), 0, 0, 8'h00);
            nextCycle();
        end

        applyStimulus(0, 1, 6'd0, 1, 6'd3, 1, 6'd5, 8'h00, 1, 6'd9, 8'hEE);
        checkReady("firstContend", 1, 0, 1, 0);
        checkOutput("firstContend.addrW", 32'(sramAddrW), 32'd5);
        checkOutput("firstContend.dinW", 32'(sramDinW), 32'h00);
        checkOutput("firstContend.addrR", 32'(sramAddrR), 32'd0);
        checkResp("firstContend", 0, 0, 8'h00);
        nextCycle();
        idle();
        checkResp("firstResp", 1, 0, 8'h00);
        checkOutput("idle.weW", 32'(sramWeW), 32'd0);
        nextCycle();

        $display("[TB] single write then read latency");
        applyStimulus(0, 0, 6'd0, 0, 6'd0, 0, 6'd0, 8'h00, 1, 6'd7, 8'hA5);
        checkReady("wrA5", 0, 0, 0, 1);
        checkOutput("wrA5.addrW", 32'(sramAddrW), 32'd7);
        checkOutput("wrA5.dinW", 32'(sramDinW), 32'hA5);
        nextCycle();
        idle();
        nextCycle();
        applyStimulus(0, 0, 6'd0, 1, 6'd7, 0, 6'd0, 8'h00, 0, 6'd0, 8'h00);
        checkReady("rd7", 0, 1, 0, 0);
        checkOutput("rd7.addrR", 32'(sramAddrR), 32'd7);
        checkResp("rd7.sameCycle", 0, 0, 8'h00);
        nextCycle();
        idle();
        checkResp("rd7.resp", 0, 1, 8'hA5);
        nextCycle();

        $display("[TB] contention fairness");
        applyStimulus(0, 0, 6'd0, 0, 6'd0, 1, 6'd1, 8'h11, 1, 6'd2, 8'h22);
        checkReady("pre11", 0, 0, 1, 0);
        checkOutput("pre11.dinW", 32'(sramDinW), 32'h11);
        nextCycle();
        applyStimulus(0, 0, 6'd0, 0, 6'd0, 0, 6'd0, 8'h00, 1, 6'd2, 8'h22);
        checkReady("pre22", 0, 0, 0, 1);
        checkOutput("pre22.addrW", 32'(sramAddrW), 32'd2);
        nextCycle();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 1, 6'd1, 1, 6'd2, 0, 6'd0, 8'h00, 0, 6'd0, 8'h00);
            checkReady($sformatf("fair%0d", k), (k % 2) == 0, (k % 2) == 1, 0, 0);
            checkOutput($sformatf("fair%0d.addrR", k), 32'(sramAddrR), (k % 2) == 0 ? 32'd1 : 32'd2);
            if (k > 0) begin
                checkResp($sformatf("fair%0d", k), (k % 2) == 1, (k % 2) == 0, (k % 2) == 1 ? 8'h11 : 8'h22);
            end
            nextCycle();
        end
        idle();
        checkResp("fairLast", 0, 1, 8'h22);
        nextCycle();

        $display("[TB] same-cycle collision");
        applyStimulus(0, 0, 6'd0, 1, 6'd5, 1, 6'd5, 8'h3C, 0, 6'd0, 8'h00);
        checkReady("coll", 0, 1, 1, 0);
        nextCycle();
        idle();
        checkResp("coll.resp", 0, 1, 8'h3C);
        nextCycle();
        applyStimulus(0, 1, 6'd5, 0, 6'd0, 0, 6'd0, 8'h00, 0, 6'd0, 8'h00);
        checkReady("coll.reread", 1, 0, 0, 0);
        nextCycle();
        idle();
        checkResp("coll.rereadResp", 1, 0, 8'h3C);
        nextCycle();

        $display("[TB] reset mid-read");
        applyStimulus(0, 1, 6'd1, 0, 6'd0, 0, 6'd0, 8'h00, 0, 6'd0, 8'h00);
        checkReady("midRd", 1, 0, 0, 0);
        nextCycle();
        applyStimulus(1, 1, 6'd1, 1, 6'd2, 1, 6'd10, 8'h77, 1, 6'd11, 8'h88);
        checkReady("midRst", 0, 0, 0, 0);
        checkResp("midRst", 0, 0, 8'h00);
        nextCycle();
        applyStimulus(0, 1, 6'd1, 1, 6'd2, 1, 6'd10, 8'h77, 1, 6'd11, 8'h88);
        checkReady("postRst", 1, 0, 1, 0);
        checkResp("postRst", 0, 0, 8'h00);
        nextCycle();
        idle();
        checkResp("postRst.resp", 1, 0, 8'h11);
        nextCycle();

        $display("[TB] full depth write and read-back");
        for (int i = 0; i < 64; i++) begin
            if (i % 2 == 0)
                applyStimulus(0, 0, 6'd0, 0, 6'd0, 1, 6'(i), 8'(i) ^ 8'h5A, 0, 6'd0, 8'h00);
            else
                applyStimulus(0, 0, 6'd0, 0, 6'd0, 0, 6'd0, 8'h00, 1, 6'(i), 8'(i) ^ 8'h5A);
            checkReady($sformatf("fillW%0d", i), 0, 0, (i % 2) == 0, (i % 2) == 1);
            nextCycle();
        end
        for (int i = 0; i < 64; i++) begin
            if (i % 2 == 0)
                applyStimulus(0, 1, 6'(i), 0, 6'd0, 0, 6'd0, 8'h00, 0, 6'd0, 8'h00);
            else
                applyStimulus(0, 0, 6'd0, 1, 6'(i), 0, 6'd0, 8'h00, 0, 6'd0, 8'h00);
            checkReady($sformatf("fillR%0d", i), (i % 2) == 0, (i % 2) == 1, 0, 0);
            if (i > 0) begin
                checkResp($sformatf("fillResp%0d", i - 1), ((i - 1) % 2) == 0, ((i - 1) % 2) == 1,
                          8'(i - 1) ^ 8'h5A);
            end
            nextCycle();
        end
        idle();
        checkResp("fillResp63", 0, 1, 8'd63 ^ 8'h5A);
        nextCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
